uart_cmd_ctrl: RTL and testbench

- Command controller sitting directly behind the UART receiver.
- Consumes the receiver's byte stream (data byte plus a one-cycle valid pulse) and assembles fixed-format command frames.
- Each good frame writes one entry of a small register bank. Register 0 drives the board LEDs; registers 1-3 are exported as configuration for downstream logic.
- Enforces an inter-byte timeout, rejects malformed frames, and counts good and bad frames.

---
 rtl/uart_cmd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: assembles SYNC/ADDR/DATA[/CSUM] frames into a 4-entry register bank.
// Latency: last byte at N, COMMIT at N+1, wr_en and outputs at N+2. No backpressure; bytes arriving in COMMIT are dropped.
// Optional checksum byte enabled by UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2080,
  parameter int         CNT_W          = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  led_out,
  output logic [23:0] cfg_out,
  output logic        wr_en,
  output logic [1:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        cmd_error,
  output logic        busy,
  output logic [7:0]  good_count,
  output logic [7:0]  err_count
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_COMMIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_COMMIT} state_t;
`endif

  state_t           state, state_nxt;
  logic [7:0]       addr_q, data_q;
  logic [7:0]       regs [4];
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_exp;
  logic             tmo_hit;
  logic             latch_addr, latch_data;
  logic             commit_good, commit_bad;
  logic             csum_ok;

`ifdef UART_CMD_CHECKSUM_EN
  logic csum_q;
  logic latch_csum;
  assign csum_ok = csum_q;
`else
  assign csum_ok = 1'b1;
`endif

  assign tmo_exp = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    latch_addr  = 1'b0;
    latch_data  = 1'b0;
    tmo_hit     = 1'b0;
    commit_good = 1'b0;
    commit_bad  = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    latch_csum  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid) begin
          latch_addr = 1'b1;
          state_nxt  = S_DATA;
        end else if (tmo_exp) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          latch_data = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
          state_nxt  = S_CSUM;
`else
          state_nxt  = S_COMMIT;
`endif
        end else if (tmo_exp) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_CSUM: begin
        if (rx_valid) begin
          latch_csum = 1'b1;
          state_nxt  = S_COMMIT;
        end else if (tmo_exp) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
`endif
      S_COMMIT: begin
        // any rx_valid seen here is intentionally ignored
        if (addr_q[7:2] == 6'd0 && csum_ok) commit_good = 1'b1;
        else                                commit_bad  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      regs[0]    <= 8'd0;
      regs[1]    <= 8'd0;
      regs[2]    <= 8'd0;
      regs[3]    <= 8'd0;
      tmo_cnt    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= 2'd0;
      wr_data    <= 8'd0;
      cmd_error  <= 1'b0;
      good_count <= 8'd0;
      err_count  <= 8'd0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q     <= 1'b0;
`endif
    end else begin
      wr_en     <= commit_good;
      cmd_error <= commit_bad | tmo_hit;

      if (rx_valid || state == S_IDLE) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (latch_addr) addr_q <= rx_data;
      if (latch_data) data_q <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
      if (latch_csum) csum_q <= (rx_data == (addr_q ^ data_q ^ SYNC_BYTE));
`endif

      if (commit_good) begin
        regs[addr_q[1:0]] <= data_q;
        wr_addr           <= addr_q[1:0];
        wr_data           <= data_q;
        good_count        <= good_count + 8'd1;
      end

      if ((commit_bad || tmo_hit) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign led_out = regs[0];
  assign cfg_out = {regs[3], regs[2], regs[1]};
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_cmd_ctrl;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 2080;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  led_out;
  logic [23:0] cfg_out;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        cmd_error;
  logic        busy;
  logic [7:0]  good_count;
  logic [7:0]  err_count;

  uart_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .led_out(led_out), .cfg_out(cfg_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cmd_error(cmd_error), .busy(busy),
    .good_count(good_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed pulse activity
  int         wr_pulses = 0;
  int         err_pulses = 0;
  int         last_wr_cyc = 0;
  int         last_err_cyc = 0;
  logic [1:0] last_wr_addr = 2'd0;
  logic [7:0] last_wr_data = 8'd0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_cyc  <= cyc;
      last_wr_addr <= wr_addr;
      last_wr_data <= wr_data;
    end
    if (cmd_error === 1'b1) begin
      err_pulses   <= err_pulses + 1;
      last_err_cyc <= cyc;
    end
  end

  // frame-level reference model
  logic [7:0] mregs [4];
  logic [7:0] m_good, m_err;
  logic [1:0] m_wr_addr;
  logic [7:0] m_wr_data;
  int         m_wr_pulses = 0;
  int         m_err_pulses = 0;
  int         last_byte_cyc = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] good_csum(input logic [7:0] a, input logic [7:0] d);
    return a ^ d ^ SYNC;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    m_good = 8'd0;
    m_err  = 8'd0;
  endtask

  task automatic model_error();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    m_err_pulses++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    last_byte_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int gap);
    bit ok;
    send_byte(SYNC, gap);
    send_byte(a, gap);
    send_byte(d, gap);
    if (CSUM_EN) send_byte(c, gap);
    ok = (a[7:2] == 6'd0) && (!CSUM_EN || c == good_csum(a, d));
    if (ok) begin
      mregs[a[1:0]] = d;
      m_good        = m_good + 8'd1;
      m_wr_addr     = a[1:0];
      m_wr_data     = d;
      m_wr_pulses++;
    end else begin
      model_error();
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_led"},    {24'd0, led_out}, {24'd0, mregs[0]});
    check({tag, "_cfg"},    {8'd0, cfg_out}, {8'd0, mregs[3], mregs[2], mregs[1]});
    check({tag, "_good"},   {24'd0, good_count}, {24'd0, m_good});
    check({tag, "_errcnt"}, {24'd0, err_count}, {24'd0, m_err});
    check({tag, "_wrpul"},  wr_pulses, m_wr_pulses);
    check({tag, "_errpul"}, err_pulses, m_err_pulses);
    check({tag, "_busy"},   {31'd0, busy}, 32'd0);
    if (m_wr_pulses > 0) begin
      check({tag, "_wraddr"}, {30'd0, last_wr_addr}, {30'd0, m_wr_addr});
      check({tag, "_wrdata"}, {24'd0, last_wr_data}, {24'd0, m_wr_data});
    end
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, d, e0;
    logic [7:0] a, dt, c, junk;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'd0;
    model_reset();
    m_wr_addr = 2'd0; m_wr_data = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    check("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
    check_all("rst");

    // good write to LEDs at UART byte timing, with latency check
    send_frame(8'h00, 8'h31, good_csum(8'h00, 8'h31), 1040);
    check("t1_latency", last_wr_cyc - last_byte_cyc, 2);
    check_all("t1");

    // out-of-range address
    send_frame(8'h07, 8'h55, good_csum(8'h07, 8'h55), 20);
    check_all("t2");

    // inter-byte timeout mid-frame
    send_byte(SYNC, 1040);
    check("t3_busy_mid", {31'd0, busy}, 32'd1);
    e0 = err_pulses;
    send_byte(8'h02, 0);
    t0 = last_byte_cyc;
    repeat (TMO - 10) @(posedge clk);
    @(negedge clk);
    check("t3_no_early_tmo", err_pulses, e0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    model_error();
    d = last_err_cyc - t0;
    check("t3_tmo_delay", {31'd0, (d == TMO || d == TMO + 1)}, 32'd1);
    check_all("t3");
    send_frame(8'h02, 8'hAA, good_csum(8'h02, 8'hAA), 20);
    check("t3_cfg_reg2", {24'd0, cfg_out[15:8]}, 32'hAA);
    check_all("t3b");

    // leading junk dropped; SYNC value as data
    send_byte(8'h31, 20);
    send_frame(8'h01, 8'hA5, good_csum(8'h01, 8'hA5), 20);
    check("t4_cfg_reg1", {24'd0, cfg_out[7:0]}, 32'hA5);
    check_all("t4");

    if (CSUM_EN) begin
      send_frame(8'h03, 8'h0F, 8'h59, 10);
      check_all("t5_bad");
      send_frame(8'h03, 8'h0F, 8'hA9, 10);
      check("t5_cfg_reg3", {24'd0, cfg_out[23:16]}, 32'h0F);
      check_all("t5_good");
    end

    // randomized frames
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == SYNC) junk = 8'h3C;
        send_byte(junk, $urandom_range(0, 6));
      end
      a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      dt = 8'($urandom_range(0, 255));
      c  = good_csum(a, dt);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_frame(a, dt, c, $urandom_range(0, 8));
      check_all("rand");
    end

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      a = 8'h80 | 8'($urandom_range(0, 127));
      send_frame(a, 8'h11, good_csum(a, 8'h11), 0);
    end
    check("sat_errcnt", {24'd0, err_count}, 32'hFF);
    check_all("sat");

    // good counter wrap
    for (int i = 0; i < 256; i++) begin
      dt = 8'(i);
      send_frame(8'h01, dt, good_csum(8'h01, dt), 0);
    end
    check_all("wrap");

    // reset between DATA byte and COMMIT
    send_frame(8'h00, 8'h77, good_csum(8'h00, 8'h77), 2);
    send_byte(SYNC, 2);
    send_byte(8'h01, 2);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mrst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mrst_wr_addr", {30'd0, wr_addr}, 32'd0);
    check("mrst_wr_data", {24'd0, wr_data}, 32'd0);
    check("mrst_led", {24'd0, led_out}, 32'd0);
    check("mrst_cfg", {8'd0, cfg_out}, 32'd0);
    check("mrst_good", {24'd0, good_count}, 32'd0);
    check("mrst_err", {24'd0, err_count}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_wrpul", wr_pulses, m_wr_pulses);
    check("mrst_errpul", err_pulses, m_err_pulses);

    send_frame(8'h00, 8'h5C, good_csum(8'h00, 8'h5C), 3);
    check_all("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
